can_destuffer_fd: RTL and testbench
===================================

Name: can_destuffer_fd

Overview:
Parametrised CAN / CAN FD receive bit-stream destuffer.
- Selects the active sample strobe per bit phase: nominal, or data phase after BRS.
- Removes dynamic stuff bits and FD fixed stuff bits, and flags stuff violations.
- Keeps the modulo stuff count used in the FD CRC field.
- Sits between the bit-timing unit and the frame decoder FSM; outputs only destuffed data bits.

Parameters:
STUFF_LEN, 5, number of equal consecutive bits after which a dynamic stuff bit is expected (>=2)
FIXED_PERIOD, 4, data bits between FD fixed stuff bits (>=2)
CNT_WIDTH, 3, stuff-count width; count wraps modulo 2**CNT_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
samplePoint  in  1  nominal-rate sample strobe, 1-cycle pulse
samplePointFD  in  1  data-rate sample strobe, 1-cycle pulse
edl  in  1  frame is FD (level, from frame decoder)
brs  in  1  bit-rate-switch bit value (level)
brsStop  in  1  return to nominal rate (level or pulse)
canRX  in  1  synchronised RX bit
bsOnOff  in  1  1 = dynamic destuffing enabled
fixedMode  in  1  1 = FD fixed-stuff region (CRC field)
sofSync  in  1  marks the SOF strobe; restarts all tracking
bitValid  out  1  pulse: destuffed data bit available on bitOut
bitOut  out  1  destuffed bit value
stuffing  out  1  pulse: stuff bit removed (dynamic or fixed)
bsError  out  1  pulse: dynamic stuff rule violated
fixedStuffError  out  1  pulse: fixed stuff bit not complement of previous bit
fastPhase  out  1  1 while samplePointFD is the active strobe
stuffCount  out  CNT_WIDTH  dynamic stuff bits removed since SOF, modulo 2**CNT_WIDTH

Behaviour:
- One clock, async active-low reset rst_n. All outputs registered.
- Reset values:
  - all outputs 0
  - internal lastBit=1, runCount=0, fixedCnt=0, fixedPrev=0.
- runCount width is $clog2(STUFF_LEN+1).
- Strobe select:
  - strobe = fastPhase ? samplePointFD : samplePoint. The other strobe is ignored.
  - fastPhase is set at a samplePoint strobe with edl=1 and brs=1, while bsOnOff=1 and fixedMode=0.
  - fastPhase is cleared in any cycle with brsStop=1 or sofSync=1.
  - Clear has priority over set.
  - A change applies from the next cycle's strobe.
- All result pulses (bitValid, stuffing, bsError, fixedStuffError) appear exactly 1 cycle after the strobe and last 1 cycle.
- At most one of the following per strobe: bitValid, stuffing, bsError, fixedStuffError.
- sofSync with a strobe in the same cycle:
  - Reinitialise: runCount=0, lastBit=1, stuffCount=0, fastPhase=0, fixedCnt=0, fixedPrev=0.
  - Then process canRX as an ordinary data bit.
  - Result: bitValid=1, runCount=1, lastBit=canRX.
  - sofSync without a strobe only reinitialises.
- Dynamic mode (bsOnOff=1, fixedMode=0), per strobe:
  - runCount==STUFF_LEN, canRX!=lastBit: stuff bit. stuffing=1, stuffCount+1 (wraps), runCount=1, lastBit=canRX.
  - runCount==STUFF_LEN, canRX==lastBit: bsError=1, runCount=1, lastBit=canRX, no bitValid.
  - Otherwise: bitValid=1, bitOut=canRX. runCount = (canRX==lastBit) ? runCount+1 : 1. lastBit=canRX.
  - A stuff bit starts a new run.
- Pass-through (bsOnOff=0, fixedMode=0):
  - Every strobe gives bitValid with bitOut=canRX, never an error.
  - runCount is forced to 1 and lastBit tracks canRX.
- Fixed mode (fixedMode=1, any bsOnOff):
  - First strobe after fixedMode rises is a fixed stuff bit. Checked against lastBit: canRX!=lastBit gives stuffing=1, otherwise fixedStuffError=1.
  - Then fixedCnt counts data bits 1..FIXED_PERIOD, each emitted with bitValid.
  - The strobe after fixedCnt==FIXED_PERIOD is again a fixed stuff bit, checked the same way, and resets fixedCnt=0.
  - stuffCount is frozen in fixed mode. No dynamic checking.
  - lastBit follows every received bit.
- fixedMode falling: next strobe is handled in dynamic mode with runCount=1.
- Reset mid-frame: everything returns to reset values immediately. Any in-flight pulse is suppressed.

Test Plan:
- SOF, then bits 0,0,0,0 (5 zeros incl. SOF), then 1, then 1,0 -> 5 bitValid pulses; 1 stuffing pulse 1 cycle after the 6th strobe; stuffCount=1; then 2 bitValid with bitOut=1,0.
- SOF + 4 zeros, then a 6th 0 -> bsError pulse after the 6th strobe, no bitValid; the next 0 is a data bit with runCount=2.
- bsOnOff=0, 8 consecutive 0 -> 8 bitValid, bsError never asserted, stuffCount unchanged.
- edl=1, brs=1 at a samplePoint strobe -> fastPhase=1 next cycle; later samplePoint pulses produce nothing, samplePointFD pulses produce bits; brsStop=1 -> fastPhase=0, samplePoint active again.
- fixedMode=1, lastBit=0, stream 1,a,b,c,d,~d -> stuffing, 4 bitValid, stuffing. Same stream with the 6th bit = d -> fixedStuffError; stuffCount unchanged throughout.
- 8 dynamic stuff bits after SOF -> stuffCount wraps 7->0.
- rst_n low mid-run -> all outputs 0 asynchronously.
- sofSync on a strobe -> stuffCount=0, fastPhase=0, bitValid=1.

Source files
------------

// File: rtl/can_destuffer_fd_if.sv
// Bit-stream link between the bit-timing unit/frame decoder and the destuffer.
interface can_destuffer_fd_if #(
    parameter int unsigned CNT_WIDTH = 3
);
    logic                 samplePoint;
    logic                 samplePointFD;
    logic                 edl;
    logic                 brs;
    logic                 brsStop;
    logic                 canRX;
    logic                 bsOnOff;
    logic                 fixedMode;
    logic                 sofSync;
    logic                 bitValid;
    logic                 bitOut;
    logic                 stuffing;
    logic                 bsError;
    logic                 fixedStuffError;
    logic                 fastPhase;
    logic [CNT_WIDTH-1:0] stuffCount;

    // Upstream side: drives strobes, RX bit and frame context
    modport master (
        output samplePoint, samplePointFD, edl, brs, brsStop, canRX,
               bsOnOff, fixedMode, sofSync,
        input  bitValid, bitOut, stuffing, bsError, fixedStuffError,
               fastPhase, stuffCount
    );

    // Destuffer side
    modport slave (
        input  samplePoint, samplePointFD, edl, brs, brsStop, canRX,
               bsOnOff, fixedMode, sofSync,
        output bitValid, bitOut, stuffing, bsError, fixedStuffError,
               fastPhase, stuffCount
    );
endinterface

// File: rtl/can_destuffer_fd.sv
// CAN / CAN FD receive destuffer: strobe selection, dynamic and fixed
// stuff-bit removal, violation flags and modulo stuff count.
module can_destuffer_fd #(
    parameter int unsigned STUFF_LEN    = 5,
    parameter int unsigned FIXED_PERIOD = 4,
    parameter int unsigned CNT_WIDTH    = 3
) (
    input logic               clk,
    input logic               rst_n,
    can_destuffer_fd_if.slave bus
);
    localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
    localparam int unsigned FIX_W = $clog2(FIXED_PERIOD + 1);

    logic [RUN_W-1:0]     run_count, run_next;
    logic                 last_bit, last_next;
    logic [FIX_W-1:0]     fixed_cnt, fixed_cnt_next;
    logic                 fixed_prev, fixed_prev_next;
    logic [CNT_WIDTH-1:0] stuff_count, stuff_count_next;
    logic                 fast_phase, fast_phase_next;
    logic                 bit_valid, bit_valid_next;
    logic                 bit_out, bit_out_next;
    logic                 stuffing, stuffing_next;
    logic                 bs_error, bs_error_next;
    logic                 fixed_error, fixed_error_next;

    logic                 strobe_c;
    logic [RUN_W-1:0]     run_cur;
    logic                 last_cur;
    logic [FIX_W-1:0]     fixed_cnt_cur;
    logic                 fixed_prev_cur;
    logic [CNT_WIDTH-1:0] stuff_cur;

    // Next-state and result decode for the active strobe; SOF reinitialises
    // the tracking state before the SOF bit itself is processed.
    always_comb begin
        strobe_c       = fast_phase ? bus.samplePointFD : bus.samplePoint;
        run_cur        = bus.sofSync ? '0 : run_count;
        last_cur       = bus.sofSync ? 1'b1 : last_bit;
        fixed_cnt_cur  = bus.sofSync ? '0 : fixed_cnt;
        fixed_prev_cur = bus.sofSync ? 1'b0 : fixed_prev;
        stuff_cur      = bus.sofSync ? '0 : stuff_count;

        run_next         = run_cur;
        last_next        = last_cur;
        fixed_cnt_next   = fixed_cnt_cur;
        fixed_prev_next  = fixed_prev_cur;
        stuff_count_next = stuff_cur;
        fast_phase_next  = fast_phase;
        bit_valid_next   = 1'b0;
        bit_out_next     = bit_out;
        stuffing_next    = 1'b0;
        bs_error_next    = 1'b0;
        fixed_error_next = 1'b0;

        if (strobe_c) begin
            last_next       = bus.canRX;
            fixed_prev_next = bus.fixedMode;
            if (bus.fixedMode) begin
                // Fixed region: stuff bit on entry and after every FIXED_PERIOD data bits
                run_next = RUN_W'(1);
                if (!fixed_prev_cur || fixed_cnt_cur == FIX_W'(FIXED_PERIOD)) begin
                    fixed_cnt_next = '0;
                    if (bus.canRX != last_cur) begin
                        stuffing_next = 1'b1;
                    end else begin
                        fixed_error_next = 1'b1;
                    end
                end else begin
                    fixed_cnt_next = fixed_cnt_cur + FIX_W'(1);
                    bit_valid_next = 1'b1;
                    bit_out_next   = bus.canRX;
                end
            end else begin
                fixed_cnt_next = '0;
                if (!bus.bsOnOff) begin
                    run_next       = RUN_W'(1);
                    bit_valid_next = 1'b1;
                    bit_out_next   = bus.canRX;
                end else if (run_cur == RUN_W'(STUFF_LEN)) begin
                    // A stuff bit (or the violating bit) opens a new run
                    run_next = RUN_W'(1);
                    if (bus.canRX != last_cur) begin
                        stuffing_next    = 1'b1;
                        stuff_count_next = stuff_cur + CNT_WIDTH'(1);
                    end else begin
                        bs_error_next = 1'b1;
                    end
                end else begin
                    run_next       = (bus.canRX == last_cur) ? run_cur + RUN_W'(1) : RUN_W'(1);
                    bit_valid_next = 1'b1;
                    bit_out_next   = bus.canRX;
                end
            end
            if (!fast_phase && bus.edl && bus.brs && bus.bsOnOff && !bus.fixedMode) begin
                fast_phase_next = 1'b1;
            end
        end

        if (bus.brsStop || bus.sofSync) begin
            fast_phase_next = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_count   <= '0;
            last_bit    <= 1'b1;
            fixed_cnt   <= '0;
            fixed_prev  <= 1'b0;
            stuff_count <= '0;
            fast_phase  <= 1'b0;
            bit_valid   <= 1'b0;
            bit_out     <= 1'b0;
            stuffing    <= 1'b0;
            bs_error    <= 1'b0;
            fixed_error <= 1'b0;
        end else begin
            run_count   <= run_next;
            last_bit    <= last_next;
            fixed_cnt   <= fixed_cnt_next;
            fixed_prev  <= fixed_prev_next;
            stuff_count <= stuff_count_next;
            fast_phase  <= fast_phase_next;
            bit_valid   <= bit_valid_next;
            bit_out     <= bit_out_next;
            stuffing    <= stuffing_next;
            bs_error    <= bs_error_next;
            fixed_error <= fixed_error_next;
        end
    end

    assign bus.bitValid        = bit_valid;
    assign bus.bitOut          = bit_out;
    assign bus.stuffing        = stuffing;
    assign bus.bsError         = bs_error;
    assign bus.fixedStuffError = fixed_error;
    assign bus.fastPhase       = fast_phase;
    assign bus.stuffCount      = stuff_count;
endmodule

// File: tb/tb_can_destuffer_fd.sv
// Directed bench for can_destuffer_fd (STUFF_LEN=5, FIXED_PERIOD=4, CNT_WIDTH=3).
module tb_can_destuffer_fd;
    localparam logic [3:0] P_0 = 4'b0000;
    localparam logic [3:0] P_V = 4'b1000;
    localparam logic [3:0] P_S = 4'b0100;
    localparam logic [3:0] P_E = 4'b0010;
    localparam logic [3:0] P_F = 4'b0001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    can_destuffer_fd_if #(.CNT_WIDTH(3)) bus ();

    can_destuffer_fd #(
        .STUFF_LEN(5),
        .FIXED_PERIOD(4),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result pulses packed as {bitValid, stuffing, bsError, fixedStuffError}
    function automatic logic [3:0] pulses();
        return {bus.bitValid, bus.stuffing, bus.bsError, bus.fixedStuffError};
    endfunction

    // Drive one cycle starting at a negedge; returns at the next negedge
    task automatic tick(input logic sp, input logic spfd, input logic rx, input logic sof);
        bus.samplePoint   = sp;
        bus.samplePointFD = spfd;
        bus.canRX         = rx;
        bus.sofSync       = sof;
        @(negedge clk);
        bus.samplePoint   = 1'b0;
        bus.samplePointFD = 1'b0;
        bus.sofSync       = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pulses(), bus.bitOut, bus.fastPhase, bus.stuffCount} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b expected 0", {pulses(), bus.bitOut, bus.fastPhase, bus.stuffCount});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dynamic_stuff();
        logic       rx_seq [8];
        logic [3:0] exp_p  [8];
        logic       exp_b  [8];
        rx_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_p  = '{P_V, P_V, P_V, P_V, P_V, P_S, P_V, P_V};
        exp_b  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, rx_seq[i], (i == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if (pulses() !== exp_p[i]) begin
                n_fail++;
                $display("FAIL dyn_stuff[%0d] pulses: got %b expected %b", i, pulses(), exp_p[i]);
            end
            if (exp_p[i] == P_V) begin
                n_checks++;
                if (bus.bitOut !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL dyn_stuff[%0d] bitOut: got %b expected %b", i, bus.bitOut, exp_b[i]);
                end
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pulses() !== P_0) begin
            n_fail++;
            $display("FAIL dyn_stuff idle pulses: got %b expected %b", pulses(), P_0);
        end
        n_checks++;
        if (bus.stuffCount !== 3'd1) begin
            n_fail++;
            $display("FAIL dyn_stuff stuffCount: got %0d expected 1", bus.stuffCount);
        end
    endtask

    task automatic test_pass_through();
        bus.bsOnOff = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (pulses() !== P_V || bus.bitOut !== 1'b0) begin
                n_fail++;
                $display("FAIL pass_through[%0d]: got pulses %b bit %b expected %b bit 0", i, pulses(), bus.bitOut, P_V);
            end
        end
        n_checks++;
        if (bus.stuffCount !== 3'd1) begin
            n_fail++;
            $display("FAIL pass_through stuffCount: got %0d expected 1", bus.stuffCount);
        end
        bus.bsOnOff = 1'b1;
    endtask

    task automatic test_bs_error();
        logic [3:0] exp_p [11];
        exp_p = '{P_V, P_V, P_V, P_V, P_V, P_E, P_V, P_V, P_V, P_V, P_E};
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if (pulses() !== exp_p[i]) begin
                n_fail++;
                $display("FAIL bs_error[%0d] pulses: got %b expected %b", i, pulses(), exp_p[i]);
            end
        end
        n_checks++;
        if (bus.stuffCount !== 3'd0) begin
            n_fail++;
            $display("FAIL bs_error stuffCount: got %0d expected 0", bus.stuffCount);
        end
    endtask

    task automatic test_fast_phase();
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        bus.edl = 1'b1;
        bus.brs = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        bus.edl = 1'b0;
        bus.brs = 1'b0;
        n_checks++;
        if (bus.fastPhase !== 1'b1 || pulses() !== P_V || bus.bitOut !== 1'b1) begin
            n_fail++;
            $display("FAIL brs_bit: got fast %b pulses %b bit %b expected fast 1 pulses %b bit 1", bus.fastPhase, pulses(), bus.bitOut, P_V);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pulses() !== P_0) begin
            n_fail++;
            $display("FAIL fast_ignores_nominal: got %b expected %b", pulses(), P_0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_bit0: got pulses %b bit %b expected %b bit 0", pulses(), bus.bitOut, P_V);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_bit1: got pulses %b bit %b expected %b bit 1", pulses(), bus.bitOut, P_V);
        end
        bus.brsStop = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        bus.brsStop = 1'b0;
        n_checks++;
        if (bus.fastPhase !== 1'b0) begin
            n_fail++;
            $display("FAIL brs_stop fastPhase: got %b expected 0", bus.fastPhase);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (pulses() !== P_0) begin
            n_fail++;
            $display("FAIL nominal_ignores_fd: got %b expected %b", pulses(), P_0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_again: got pulses %b bit %b expected %b bit 0", pulses(), bus.bitOut, P_V);
        end
    endtask

    task automatic test_fixed();
        logic       rx_seq [12];
        logic [3:0] exp_p  [12];
        // SOF, 4 zeros, dynamic stuff 1, then data 0 so lastBit=0
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, (i == 5) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0);
        end
        n_checks++;
        if (bus.stuffCount !== 3'd1 || pulses() !== P_V) begin
            n_fail++;
            $display("FAIL fixed_setup: got cnt %0d pulses %b expected cnt 1 pulses %b", bus.stuffCount, pulses(), P_V);
        end
        bus.fixedMode = 1'b1;
        rx_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_p  = '{P_S, P_V, P_V, P_V, P_V, P_S, P_V, P_V, P_V, P_V, P_F, P_V};
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, 1'b0, rx_seq[i], 1'b0);
            n_checks++;
            if (pulses() !== exp_p[i]) begin
                n_fail++;
                $display("FAIL fixed[%0d] pulses: got %b expected %b", i, pulses(), exp_p[i]);
            end
            if (exp_p[i] == P_V) begin
                n_checks++;
                if (bus.bitOut !== rx_seq[i]) begin
                    n_fail++;
                    $display("FAIL fixed[%0d] bitOut: got %b expected %b", i, bus.bitOut, rx_seq[i]);
                end
            end
        end
        n_checks++;
        if (bus.stuffCount !== 3'd1) begin
            n_fail++;
            $display("FAIL fixed stuffCount: got %0d expected 1", bus.stuffCount);
        end
        bus.fixedMode = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_exit: got pulses %b bit %b expected %b bit 1", pulses(), bus.bitOut, P_V);
        end
    endtask

    task automatic test_count_wrap();
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick(1'b1, 1'b0, (k % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
            end
            tick(1'b1, 1'b0, (k % 2 == 1) ? 1'b0 : 1'b1, 1'b0);
            n_checks++;
            if (pulses() !== P_S || bus.stuffCount !== 3'((k + 1) % 8)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pulses %b cnt %0d expected %b cnt %0d", k, pulses(), bus.stuffCount, P_S, (k + 1) % 8);
            end
        end
    endtask

    task automatic test_sof_reinit();
        bus.edl = 1'b1;
        bus.brs = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        bus.edl = 1'b0;
        bus.brs = 1'b0;
        n_checks++;
        if (bus.fastPhase !== 1'b1 || bus.stuffCount !== 3'd1) begin
            n_fail++;
            $display("FAIL sof_setup: got fast %b cnt %0d expected fast 1 cnt 1", bus.fastPhase, bus.stuffCount);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b0 || bus.stuffCount !== 3'd0 || bus.fastPhase !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_reinit: got pulses %b bit %b cnt %0d fast %b expected %b bit 0 cnt 0 fast 0", pulses(), bus.bitOut, bus.stuffCount, bus.fastPhase, P_V);
        end
    endtask

    task automatic test_reset_midrun();
        // Continue the frame from SOF(0): four more zeros then a stuff bit
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        bus.edl = 1'b1;
        bus.brs = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        bus.edl = 1'b0;
        bus.brs = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b1 || bus.fastPhase !== 1'b1 || bus.stuffCount !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset: got pulses %b bit %b fast %b cnt %0d expected %b bit 1 fast 1 cnt 1", pulses(), bus.bitOut, bus.fastPhase, bus.stuffCount, P_V);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pulses(), bus.bitOut, bus.fastPhase, bus.stuffCount} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0", {pulses(), bus.bitOut, bus.fastPhase, bus.stuffCount});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pulses() !== P_V || bus.bitOut !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: got pulses %b bit %b expected %b bit 1", pulses(), bus.bitOut, P_V);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.samplePoint   = 1'b0;
        bus.samplePointFD = 1'b0;
        bus.edl           = 1'b0;
        bus.brs           = 1'b0;
        bus.brsStop       = 1'b0;
        bus.canRX         = 1'b1;
        bus.bsOnOff       = 1'b1;
        bus.fixedMode     = 1'b0;
        bus.sofSync       = 1'b0;
        test_reset();
        test_dynamic_stuff();
        test_pass_through();
        test_bs_error();
        test_fast_phase();
        test_fixed();
        test_count_wrap();
        test_sof_reinit();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
